systolic_skew_feeder: RTL and testbench

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder_pkg.sv | 16 +
 rtl/systolic_skew_feeder_skew_fifo.sv | 74 +++++++
 rtl/systolic_skew_feeder.sv | 150 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared systolic-array definitions: controller state encoding and default
// operand/array dimensions. The MAC array and its feeders import this package
// so they agree on widths and state names.
package systolic_skew_feeder_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultRows      = 4;
    localparam int unsigned DefaultFifoDepth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/systolic_skew_feeder_skew_fifo.sv
// skew_fifo: synchronous FIFO with registered storage and no fall-through.
// An entry written on one edge can be read at the earliest on the next edge.
// Ports:
//   clk_i, reset_i       clock and asynchronous active-high reset
//   wr_en_i, wr_data_i   write request and data (ignored while full)
//   rd_en_i, rd_data_o   read request (ignored while empty) and head entry
//   full_o, empty_o      occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module skew_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);
    localparam int unsigned CntWidth  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [AddrWidth-1:0] wptr_q, wptr_d;
    logic [AddrWidth-1:0] rptr_q, rptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic                 wr_fire, rd_fire;

    assign full_o    = (count_q == CntWidth'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_fire   = wr_en_i && !full_o;
    assign rd_fire   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_fire) begin
            wptr_d = wptr_q + AddrWidth'(1);
        end
        if (rd_fire) begin
            rptr_d = rptr_q + AddrWidth'(1);
        end
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers operand vectors and feeds them into a systolic
// MAC array with a diagonal skew, so element r reaches MAC row r r cycles after
// element 0 reaches row 0. A tile ends with a vector flagged last; the feeder
// then drains the skew pipeline and pulses done as the last element leaves.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   in_valid/in_ready       vector handshake; in_vec element r at [r*DW +: DW]
//   in_last                 marks the final vector of a tile
//   stall                   freezes popping, skew lanes and the controller
//   row_data/row_control    registered skewed data and enable per MAC row
//   busy                    controller active or vectors still queued
//   done                    one-cycle pulse when a tile fully leaves the skew
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ROWS       = DefaultRows,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_vec,
    input  logic                       in_last,
    input  logic                       stall,
    output logic [ROWS*DATA_WIDTH-1:0] row_data,
    output logic [ROWS-1:0]            row_control,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned VecWidth   = ROWS * DATA_WIDTH;
    localparam int unsigned EntryWidth = VecWidth + 1;
    // Drain counter runs 0..ROWS-2.
    localparam int unsigned CntWidth   = (ROWS > 2) ? $clog2(ROWS - 1) : 1;

    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [EntryWidth-1:0] fifo_wdata, fifo_rdata;
    logic [VecWidth-1:0]   pop_vec;
    logic                  pop_last;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   drain_cnt_q, drain_cnt_d;
    logic                  done_q, done_d;

    // Refusing input during DRAIN keeps the next tile out of the skew until the
    // current one has fully left, so done always marks a clean tile boundary.
    assign in_ready   = !fifo_full && (state_q != StDrain);
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && !stall && (state_q != StDrain);
    assign fifo_wdata = {in_vec, in_last};
    assign pop_vec    = fifo_rdata[EntryWidth-1:1];
    assign pop_last   = fifo_rdata[0];

    skew_fifo #(
        .WIDTH (EntryWidth),
        .DEPTH (FIFO_DEPTH)
    ) u_skew_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (push),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Controller. pop already includes !stall, so IDLE/RUN need no stall term.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle, StRun: begin
                if (pop) begin
                    state_d = pop_last ? StDrain : StRun;
                end
            end
            StDrain: begin
                // ROWS-1 unstalled edges move the last element from lane 0 to
                // the end of lane ROWS-1; done rises with it.
                if (!stall) begin
                    if (drain_cnt_q == CntWidth'(ROWS - 2)) begin
                        state_d     = StIdle;
                        drain_cnt_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + CntWidth'(1);
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q != StIdle) || !fifo_empty;
    assign done = done_q;

    // Skew lanes: lane r is an (r+1)-deep shift register whose first stage is
    // loaded on the pop edge, so its output trails row 0 by exactly r edges.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [r:0][DATA_WIDTH-1:0] data_q, data_d;
        logic [r:0]                 ctrl_q, ctrl_d;

        always_comb begin
            data_d = data_q;
            ctrl_d = ctrl_q;
            if (!stall) begin
                data_d[0] = pop ? pop_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                ctrl_d[0] = pop;
                for (int s = 1; s <= r; s++) begin
                    data_d[s] = data_q[s-1];
                    ctrl_d[s] = ctrl_q[s-1];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                ctrl_q <= '0;
            end else begin
                data_q <= data_d;
                ctrl_q <= ctrl_d;
            end
        end

        assign row_data[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r];
        assign row_control[r]                       = ctrl_q[r];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

    localparam int DW    = 8;
    localparam int ROWS  = 4;
    localparam int DEPTH = 4;
    localparam int VW    = DW * ROWS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_vec = '0;
    logic          in_last = 1'b0;
    logic          stall = 1'b0;
    logic [VW-1:0] row_data;
    logic [ROWS-1:0] row_control;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_pass  = 0;
    bit sim_end = 1'b0;

    systolic_skew_feeder #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .in_last     (in_last),
        .stall       (stall),
        .row_data    (row_data),
        .row_control (row_control),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- Behavioural model ----------------
    // Queue of accepted vectors; history of what entered the skew on each
    // unstalled edge. Row r shows the slot entered r unstalled edges ago.
    typedef struct {
        logic [VW-1:0] vec;
        bit            last;
    } ent_t;
    typedef struct {
        bit            v;
        logic [VW-1:0] vec;
        bit            last;
    } slot_t;

    ent_t  mq[$];
    slot_t hist[$];
    int    last_pop_idx;
    bit    tile_open;
    bit    exp_done;

    // Draining: fewer than ROWS-1 unstalled edges since the last tile-ending pop.
    function automatic bit m_drain();
        return (last_pop_idx >= 0) && ((hist.size() - last_pop_idx) < ROWS);
    endfunction

    initial begin : model
        bit    rdy, do_push, do_pop;
        ent_t  e;
        slot_t s;
        last_pop_idx = -1;
        tile_open    = 1'b0;
        exp_done     = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                hist.delete();
                last_pop_idx = -1;
                tile_open    = 1'b0;
                exp_done     = 1'b0;
            end else begin
                rdy     = (mq.size() < DEPTH) && !m_drain();
                do_push = in_valid && rdy;
                do_pop  = (mq.size() > 0) && !stall && !m_drain();
                e.vec   = '0;
                e.last  = 1'b0;
                if (do_pop) e = mq.pop_front();
                if (do_push) begin
                    ent_t n;
                    n.vec  = in_vec;
                    n.last = in_last;
                    mq.push_back(n);
                end
                if (!stall) begin
                    s.v    = do_pop;
                    s.vec  = do_pop ? e.vec : '0;
                    s.last = do_pop && e.last;
                    hist.push_back(s);
                    if (do_pop) begin
                        if (e.last) begin
                            last_pop_idx = hist.size() - 1;
                            tile_open    = 1'b0;
                        end else begin
                            tile_open = 1'b1;
                        end
                    end
                    exp_done = 1'b0;
                    if (hist.size() >= ROWS) begin
                        s        = hist[hist.size() - ROWS];
                        exp_done = s.v && s.last;
                    end
                end else begin
                    exp_done = 1'b0;
                end
            end
        end
    end

    // ---------------- Compare process ----------------
    initial begin : compare
        logic [VW-1:0]   exp_data;
        logic [ROWS-1:0] exp_ctrl;
        slot_t           s;
        forever begin
            @(negedge clk);
            if (!sim_end) begin
                exp_data = '0;
                exp_ctrl = '0;
                for (int r = 0; r < ROWS; r++) begin
                    if (hist.size() > r) begin
                        s = hist[hist.size() - 1 - r];
                        if (s.v) begin
                            exp_data[r*DW +: DW] = s.vec[r*DW +: DW];
                            exp_ctrl[r]          = 1'b1;
                        end
                    end
                end
                chk("m_row_data", 64'(row_data), 64'(exp_data));
                chk("m_row_control", 64'(row_control), 64'(exp_ctrl));
                chk("m_done", 64'(done), 64'(exp_done));
                chk("m_busy", 64'(busy),
                    64'(tile_open || m_drain() || (mq.size() > 0)));
                chk("m_in_ready", 64'(in_ready),
                    64'((mq.size() < DEPTH) && !m_drain()));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] vec_of(input int k);
        logic [VW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 8'((k * 16) + r + 1);
        return v;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) tick();
        chk("wait_idle", 64'(busy), 64'd0);
        tick();
        tick();
    endtask

    // Hold in_valid until the vector is accepted (bounded).
    task automatic push_one(input logic [VW-1:0] v, input logic l);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_vec   = v;
        in_last  = l;
        for (int i = 0; i < 40 && !taken; i++) begin
            taken = in_ready;
            tick();
        end
        chk("push_accepted", 64'(taken), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic single_tile();
        in_valid = 1'b1;
        in_vec   = 32'h0907_0503;
        in_last  = 1'b1;
        tick();                                   // E0: accepted
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();                                   // E1: popped
        chk("t1_row0", 64'(row_data), 64'h0000_0003);
        chk("t1_ctrl0", 64'(row_control), 64'b0001);
        tick();
        chk("t1_row1", 64'(row_data), 64'h0000_0500);
        chk("t1_ctrl1", 64'(row_control), 64'b0010);
        tick();
        chk("t1_row2", 64'(row_data), 64'h0007_0000);
        chk("t1_done_early", 64'(done), 64'd0);
        tick();
        chk("t1_row3", 64'(row_data), 64'h0900_0000);
        chk("t1_ctrl3", 64'(row_control), 64'b1000);
        chk("t1_done", 64'(done), 64'd1);
        tick();
        chk("t1_done_clear", 64'(done), 64'd0);
        chk("t1_ctrl_clear", 64'(row_control), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
    endtask

    initial begin : stim
        int done_at;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_row_data", 64'(row_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        tick();

        // Single vector tile
        single_tile();
        wait_idle();

        // Four back-to-back vectors, last on the fourth
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            in_vec   = vec_of(i);
            in_last  = (i == 3);
            tick();
            if (i == 4) chk("t2_all_rows", 64'(row_control), 64'hF);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();

        // Fill the FIFO while stalled, fifth vector waits for space
        stall = 1'b1;
        for (int k = 0; k < 4; k++) push_one(vec_of(4 + k), 1'b0);
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_vec   = vec_of(8);
        in_last  = 1'b1;
        tick();
        tick();
        chk("t3_held_ready", 64'(in_ready), 64'd0);
        chk("t3_frozen_ctrl", 64'(row_control), 64'd0);
        stall = 1'b0;
        tick();                                   // first pop frees a slot
        chk("t3_first_pop", 64'(row_data), 64'(vec_of(4) & 32'hFF));
        chk("t3_ready_again", 64'(in_ready), 64'd1);
        tick();                                   // fifth vector accepted
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();

        // Two-cycle stall mid-stream delays done by two cycles
        done_at = -1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4);
            in_vec   = vec_of(9 + i);
            in_last  = (i == 3);
            stall    = (i == 3) || (i == 4);
            tick();
            if (done && done_at < 0) done_at = i;
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t4_done_edge", 64'(done_at), 64'd9);
        wait_idle();

        // Reset in the middle of DRAIN
        in_valid = 1'b1;
        in_vec   = 32'h0B0A_0908;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        tick();
        chk("t5_pre_reset_ctrl", 64'(row_control), 64'b0010);
        chk("t5_pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_row_data", 64'(row_data), 64'd0);
        chk("t5_rst_ctrl", 64'(row_control), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_done", 64'(done), 64'd0);
        end
        single_tile();
        wait_idle();

        // A (last) then B queued: input blocked in DRAIN, B pops after IDLE
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 2);
            in_vec   = (i == 0) ? 32'h4443_4241 : 32'h5453_5251;
            in_last  = 1'b1;
            tick();
            if (i == 1) chk("t6_drain_ready", 64'(in_ready), 64'd0);
            if (i == 3) chk("t6_done_early", 64'(done), 64'd0);
            if (i == 4) chk("t6_done_a", 64'(done), 64'd1);
            if (i == 5) begin
                chk("t6_b_row0", 64'(row_data), 64'h0000_0051);
                chk("t6_b_ctrl", 64'(row_control), 64'b0001);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();

        sim_end = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
